// File: rtl/axi4_stream_pkt_builder_if.sv
// AXI4-Stream channel bundle shared by the packet builder and its consumers.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TID_WIDTH-1:0]     tid;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
                  input  tready);
  modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
                  output tready);
endinterface

// File: rtl/axi4_stream_pkt_builder.sv
// Turns a length command plus words read from a 1-cycle-latency FIFO into one
// AXI4-Stream packet, through a 2-entry skid buffer for full-rate streaming.
module axi4_stream_pkt_builder #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int MAX_PKT_LEN = 256,
  parameter int LEN_WIDTH   = $clog2(MAX_PKT_LEN) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [LEN_WIDTH-1:0]   cmd_len_i,
  input  logic [TDEST_WIDTH-1:0] cmd_tdest_i,
  input  logic [TID_WIDTH-1:0]   cmd_tid_i,
  output logic                   fifo_rd_o,
  input  logic [TDATA_WIDTH-1:0] fifo_data_i,
  input  logic                   fifo_empty_i,
  output logic                   busy_o,
  axi4_stream_if.master          pkt_o
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   rd_rem_q, rd_rem_d;
  logic [LEN_WIDTH-1:0]   out_rem_q, out_rem_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;

  logic [TDATA_WIDTH-1:0] buf_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             count_q;
  logic                   rd_pend_q;

  logic                   out_valid, pop, fifo_rd;
  logic [1:0]             occ_after_pop;
  logic [LEN_WIDTH-1:0]   len_clamped;

  assign out_valid   = (count_q != 2'd0);
  assign pop         = out_valid && pkt_o.tready;
  assign len_clamped = (cmd_len_i > LEN_WIDTH'(MAX_PKT_LEN)) ? LEN_WIDTH'(MAX_PKT_LEN) : cmd_len_i;

  // Credit the slot freed by this cycle's pop so back-to-back beats keep flowing.
  assign occ_after_pop = count_q - 2'(pop) + 2'(rd_pend_q);
  assign fifo_rd       = (state_q == RUN) && !fifo_empty_i && (rd_rem_q != '0) &&
                         (occ_after_pop < 2'd2);

  always_comb begin
    // NOTE: every next-state signal gets its default first so no latch is inferred.
    state_d   = state_q;
    len_d     = len_q;
    rd_rem_d  = rd_rem_q;
    out_rem_d = out_rem_q;
    tdest_d   = tdest_q;
    tid_d     = tid_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_len_i != '0) begin
          state_d   = RUN;
          len_d     = len_clamped;
          rd_rem_d  = len_clamped;
          out_rem_d = len_clamped;
          tdest_d   = cmd_tdest_i;
          tid_d     = cmd_tid_i;
        end
      end
      RUN: begin
        if (fifo_rd) rd_rem_d = rd_rem_q - 1'b1;
        if (pop) begin
          out_rem_d = out_rem_q - 1'b1;
          if (out_rem_q == LEN_WIDTH'(1)) state_d = IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state is updated with <= only; combinational blocks use =.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      rd_rem_q  <= '0;
      out_rem_q <= '0;
      tdest_q   <= '0;
      tid_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_rem_q  <= rd_rem_d;
      out_rem_q <= out_rem_d;
      tdest_q   <= tdest_d;
      tid_q     <= tid_d;
      rd_pend_q <= fifo_rd;
      if (rd_pend_q) wr_ptr_q <= ~wr_ptr_q;
      if (pop)       rd_ptr_q <= ~rd_ptr_q;
      count_q   <= count_q + 2'(rd_pend_q) - 2'(pop);
    end
  end

  // NOTE: buffer storage is deliberately not reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (rd_pend_q) buf_q[wr_ptr_q] <= fifo_data_i;
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q == RUN);
  assign fifo_rd_o   = fifo_rd;

  assign pkt_o.tvalid = out_valid;
  assign pkt_o.tdata  = buf_q[rd_ptr_q];
  assign pkt_o.tstrb  = '1;
  assign pkt_o.tkeep  = '1;
  assign pkt_o.tlast  = out_valid && (out_rem_q == LEN_WIDTH'(1));
  assign pkt_o.tuser  = TUSER_WIDTH'(out_valid && (out_rem_q == len_q));
  assign pkt_o.tdest  = tdest_q;
  assign pkt_o.tid    = tid_q;

endmodule

// File: tb/tb_axi4_stream_pkt_builder.sv
// Directed bench for axi4_stream_pkt_builder: a table of packet commands plus
// hand-written sequences for zero-length, FIFO underrun and mid-packet reset.
module tb_axi4_stream_pkt_builder;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [LEN_W-1:0] cmd_len_i;
  logic [1:0]       cmd_tdest_i;
  logic [1:0]       cmd_tid_i;
  logic             fifo_rd_o;
  logic [31:0]      fifo_data_i;
  logic             fifo_empty_i;
  logic             busy_o;

  axi4_stream_if #(.TDATA_WIDTH(32), .TUSER_WIDTH(2), .TDEST_WIDTH(2), .TID_WIDTH(2)) pkt_if ();

  axi4_stream_pkt_builder #(
    .TDATA_WIDTH(32), .TUSER_WIDTH(2), .TDEST_WIDTH(2), .TID_WIDTH(2), .MAX_PKT_LEN(MAX_LEN)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_len_i    (cmd_len_i),
    .cmd_tdest_i  (cmd_tdest_i),
    .cmd_tid_i    (cmd_tid_i),
    .fifo_rd_o    (fifo_rd_o),
    .fifo_data_i  (fifo_data_i),
    .fifo_empty_i (fifo_empty_i),
    .busy_o       (busy_o),
    .pkt_o        (pkt_if)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // FIFO model: read data appears the cycle after the read strobe.
  logic [31:0] fifo_mem [256];
  int          push_cnt   = 0;
  int          pop_cnt    = 0;
  logic        fifo_flush = 1'b0;
  assign fifo_empty_i = (push_cnt == pop_cnt);

  always @(posedge clk_i) begin
    if (fifo_flush) pop_cnt <= push_cnt;
    else if (fifo_rd_o) begin
      fifo_data_i <= fifo_mem[pop_cnt[7:0]];
      pop_cnt     <= pop_cnt + 1;
    end
  end

  task automatic push(input logic [31:0] w);
    fifo_mem[push_cnt[7:0]] = w;
    push_cnt = push_cnt + 1;
  endtask

  logic [3:0] rdy_pat = 4'hF;
  int         rdy_idx = 0;
  initial begin
    pkt_if.tready = 1'b1;
    forever begin
      @(negedge clk_i);
      pkt_if.tready = rdy_pat[rdy_idx[1:0]];
      rdy_idx++;
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  user;
    logic [1:0]  dest;
    logic [1:0]  id;
    int          cyc;
  } beat_t;

  beat_t got_q[$];
  int    unstable_cnt  = 0;
  int    late_idle_cnt = 0;

  initial begin
    beat_t b, held;
    logic  stalled, last_hs;
    stalled = 1'b0;
    last_hs = 1'b0;
    forever begin
      @(negedge clk_i);
      #2;
      if (last_hs && busy_o) late_idle_cnt++;
      b.data = pkt_if.tdata;  b.strb = pkt_if.tstrb; b.keep = pkt_if.tkeep;
      b.last = pkt_if.tlast;  b.user = pkt_if.tuser; b.dest = pkt_if.tdest;
      b.id   = pkt_if.tid;    b.cyc  = cyc;
      if (stalled && rst_i && (!pkt_if.tvalid || b.data !== held.data || b.last !== held.last ||
          b.user !== held.user || b.dest !== held.dest || b.id !== held.id))
        unstable_cnt++;
      stalled = pkt_if.tvalid && !pkt_if.tready;
      held    = b;
      last_hs = pkt_if.tvalid && pkt_if.tready && pkt_if.tlast;
      if (pkt_if.tvalid && pkt_if.tready) got_q.push_back(b);
    end
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input beat_t b);
    return {17'b0, b.data, b.strb, b.keep, b.last, b.user, b.dest, b.id};
  endfunction

  task automatic check_beats(input string tag, input int start, input int n,
                             input logic [31:0] base, input logic [1:0] dest, input logic [1:0] id);
    logic [31:0] d;
    check({tag, " beat count"}, 64'(got_q.size() - start), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (start + i < got_q.size()) begin
        d = base + 32'(i);
        check($sformatf("%s beat %0d", tag, i), pack(got_q[start + i]),
              {17'b0, d, 4'hF, 4'hF, (i == n - 1), (i == 0) ? 2'b01 : 2'b00, dest, id});
      end
    end
  endtask

  task automatic flush_fifo();
    @(negedge clk_i); fifo_flush = 1'b1;
    @(negedge clk_i); fifo_flush = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int w = 0; w < 300 && busy_o; w++) @(negedge clk_i);
    check({tag, " done before timeout"}, 64'(busy_o), 64'd0);
    repeat (4) @(negedge clk_i);
  endtask

  task automatic send_cmd(input int len, input logic [1:0] dest, input logic [1:0] id, output int hs_cyc);
    cmd_valid_i = 1'b1;
    cmd_len_i   = LEN_W'(len);
    cmd_tdest_i = dest;
    cmd_tid_i   = id;
    hs_cyc      = cyc;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic run_pkt(input string tag, input int len, input logic [1:0] dest, input logic [1:0] id,
                         input logic [3:0] rdy, input logic [31:0] base, input int n);
    int start, hs_cyc;
    rdy_pat = rdy;
    flush_fifo();
    for (int i = 0; i < n; i++) push(base + 32'(i));
    start = got_q.size();
    check({tag, " cmd_ready idle"}, 64'(cmd_ready_o), 64'd1);
    send_cmd(len, dest, id, hs_cyc);
    check({tag, " busy after cmd"}, 64'(busy_o), 64'd1);
    wait_idle(tag);
    check_beats(tag, start, n, base, dest, id);
    if (rdy == 4'hF && got_q.size() >= start + n) begin
      check({tag, " first beat latency<=3"}, 64'(got_q[start].cyc - hs_cyc <= 3), 64'd1);
      check({tag, " back-to-back span"}, 64'(got_q[start + n - 1].cyc - got_q[start].cyc), 64'(n - 1));
    end
  endtask

  typedef struct {
    int          len;
    logic [1:0]  dest;
    logic [1:0]  id;
    logic [3:0]  rdy;
    logic [31:0] base;
    int          exp_beats;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, hs_cyc, lasts;

    vecs[0] = '{len: 4,           dest: 2'd1, id: 2'd2, rdy: 4'hF,    base: 32'h10, exp_beats: 4};
    vecs[1] = '{len: 8,           dest: 2'd2, id: 2'd1, rdy: 4'b1001, base: 32'h20, exp_beats: 8};
    vecs[2] = '{len: 1,           dest: 2'd3, id: 2'd3, rdy: 4'hF,    base: 32'h30, exp_beats: 1};
    vecs[3] = '{len: MAX_LEN + 10, dest: 2'd0, id: 2'd1, rdy: 4'hF,    base: 32'h40, exp_beats: MAX_LEN};
    vecs[4] = '{len: MAX_LEN,     dest: 2'd1, id: 2'd0, rdy: 4'b0101, base: 32'h60, exp_beats: MAX_LEN};
    vecs[5] = '{len: 3,           dest: 2'd2, id: 2'd3, rdy: 4'b0011, base: 32'h90, exp_beats: 3};

    rst_i       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_len_i   = '0;
    cmd_tdest_i = '0;
    cmd_tid_i   = '0;
    repeat (3) @(negedge clk_i);
    check("reset cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("reset fifo_rd", 64'(fifo_rd_o), 64'd0);
    check("reset tvalid", 64'(pkt_if.tvalid), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    for (int v = 0; v < 6; v++)
      run_pkt($sformatf("vec%0d", v), vecs[v].len, vecs[v].dest, vecs[v].id,
              vecs[v].rdy, vecs[v].base, vecs[v].exp_beats);

    // Zero-length command is swallowed, then a single-word packet.
    rdy_pat = 4'hF;
    flush_fifo();
    start = got_q.size();
    send_cmd(0, 2'd1, 2'd1, hs_cyc);
    check("len0 stays idle", 64'(cmd_ready_o), 64'd1);
    check("len0 not busy", 64'(busy_o), 64'd0);
    repeat (4) @(negedge clk_i);
    check("len0 no beats", 64'(got_q.size() - start), 64'd0);
    run_pkt("len1", 1, 2'd2, 2'd1, 4'hF, 32'hA0, 1);

    // FIFO runs dry mid-packet: two beats, a gap, then the rest.
    flush_fifo();
    push(32'h50); push(32'h51);
    start = got_q.size();
    send_cmd(5, 2'd1, 2'd2, hs_cyc);
    repeat (8) @(negedge clk_i);
    check("underrun tvalid low", 64'(pkt_if.tvalid), 64'd0);
    check("underrun busy", 64'(busy_o), 64'd1);
    check("underrun partial beats", 64'(got_q.size() - start), 64'd2);
    push(32'h52); push(32'h53); push(32'h54);
    wait_idle("underrun");
    check_beats("underrun", start, 5, 32'h50, 2'd1, 2'd2);
    if (got_q.size() >= start + 3)
      check("underrun gap", 64'(got_q[start + 2].cyc - got_q[start + 1].cyc > 1), 64'd1);

    // Reset mid-packet abandons it; a fresh packet follows cleanly.
    flush_fifo();
    for (int i = 0; i < 6; i++) push(32'h70 + 32'(i));
    start = got_q.size();
    send_cmd(6, 2'd3, 2'd2, hs_cyc);
    for (int w = 0; w < 50 && got_q.size() - start < 3; w++) begin
      @(negedge clk_i);
      #3;
    end
    check("midreset reached beat3", 64'(got_q.size() - start >= 3), 64'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("midreset tvalid", 64'(pkt_if.tvalid), 64'd0);
    check("midreset cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("midreset fifo_rd", 64'(fifo_rd_o), 64'd0);
    check("midreset busy", 64'(busy_o), 64'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    lasts = 0;
    for (int i = start; i < got_q.size(); i++) if (got_q[i].last) lasts++;
    check("midreset short packet", 64'(got_q.size() - start < 6), 64'd1);
    check("midreset no tlast", 64'(lasts), 64'd0);
    run_pkt("postreset", 2, 2'd1, 2'd3, 4'hF, 32'hB0, 2);

    check("fields stable under stall", 64'(unstable_cnt), 64'd0);
    check("idle cycle after tlast", 64'(late_idle_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
